// File: rtl/pixel_writeback_unit.sv
// ---------------------------------------------------------------------------
// pixel_writeback_unit
//
// Purpose:
//   Takes accumulated fixed-point pixels from the pixel point processor over
//   a done/ack handshake. Each pixel is rescaled by an arithmetic right shift,
//   optionally passed through ReLU, and saturated to OUT_W bits. The result is
//   written to the output feature-map RAM at consecutive addresses, starting
//   from a programmed base address. When the programmed number of pixels has
//   been written, a one-cycle frame_done pulse goes to the layer controller.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   start          in   one-cycle pulse; latches the frame configuration
//   out_base_addr  in   first write address of the frame
//   num_pix        in   number of pixels in the frame (0 = empty frame)
//   relu_en        in   1 = clamp negative results to zero
//   pix_in         in   accumulated signed pixel from the processor
//   pix_done       in   processor result valid
//   pix_ack        out  acknowledge back to the processor
//   wr_en          out  output RAM write strobe (one cycle per pixel)
//   wr_addr        out  output RAM address (holds between writes)
//   wr_data        out  output RAM data (holds between writes)
//   busy           out  frame in progress
//   frame_done     out  one-cycle pulse once the frame is complete
// ---------------------------------------------------------------------------
module pixel_writeback_unit #(
   parameter int IN_W       = 32,
   parameter int OUT_W      = 16,
   parameter int ADDR_W     = 14,
   parameter int FRAC_SHIFT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] out_base_addr,
   input  logic [ADDR_W-1:0] num_pix,
   input  logic              relu_en,
   input  logic [IN_W-1:0]   pix_in,
   input  logic              pix_done,
   output logic              pix_ack,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [OUT_W-1:0]  wr_data,
   output logic              busy,
   output logic              frame_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_PROC,
      S_WRITE,
      S_RELEASE,
      S_DONE
   } state_t;

   // Saturation limits expressed at the input width so that the comparison
   // happens on the full shifted value.
   localparam logic signed [IN_W-1:0] MAX_VAL =
      {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] MIN_VAL =
      {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

   state_t                   r_state;
   logic signed [IN_W-1:0]   r_pix;
   logic [OUT_W-1:0]         r_data;
   logic [ADDR_W-1:0]        r_cnt;
   logic [ADDR_W-1:0]        r_addr;
   logic [ADDR_W-1:0]        r_numPix;
   logic                     r_reluEn;
   logic                     r_pixAck;
   logic                     r_wrEn;
   logic [ADDR_W-1:0]        r_wrAddr;
   logic [OUT_W-1:0]         r_wrData;
   logic                     r_busy;
   logic                     r_frameDone;

   logic signed [IN_W-1:0]   w_shifted;
   logic signed [IN_W-1:0]   w_relu;
   logic [OUT_W-1:0]         w_satData;
   logic [ADDR_W-1:0]        w_cntNext;

   assign w_cntNext = r_cnt + ADDR_W'(1);

   // Rescale, rectify and saturate the registered pixel. The shift is
   // arithmetic so negative accumulations keep their sign; ReLU is applied
   // before saturation so a rectified value can never hit the negative limit.
   always_comb begin
      w_shifted = r_pix >>> FRAC_SHIFT;
      w_relu    = w_shifted;
      if (r_reluEn && (w_shifted < 0)) begin
         w_relu = '0;
      end
      w_satData = w_relu[OUT_W-1:0];
      if (w_relu > MAX_VAL) begin
         w_satData = SAT_POS;
      end else if (w_relu < MIN_VAL) begin
         w_satData = SAT_NEG;
      end
   end

   // Frame control FSM. Every output is registered here so that reset clears
   // them immediately and no write strobe can escape after rst rises. The
   // write strobe and frame_done are single-cycle pulses, so they default low
   // each cycle. wr_addr/wr_data only change in WRITE and otherwise hold.
   // In RELEASE the ack stays high until the processor drops done, which
   // stops a lingering done from being taken as a second pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_pix       <= '0;
         r_data      <= '0;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_numPix    <= '0;
         r_reluEn    <= 1'b0;
         r_pixAck    <= 1'b0;
         r_wrEn      <= 1'b0;
         r_wrAddr    <= '0;
         r_wrData    <= '0;
         r_busy      <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         r_wrEn      <= 1'b0;
         r_frameDone <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_numPix <= num_pix;
                  r_reluEn <= relu_en;
                  r_cnt    <= '0;
                  r_addr   <= out_base_addr;
                  r_busy   <= 1'b1;
                  r_state  <= (num_pix == '0) ? S_DONE : S_WAIT;
               end
            end
            S_WAIT: begin
               if (pix_done) begin
                  r_pix   <= pix_in;
                  r_state <= S_PROC;
               end
            end
            S_PROC: begin
               r_data  <= w_satData;
               r_state <= S_WRITE;
            end
            S_WRITE: begin
               r_wrEn   <= 1'b1;
               r_wrAddr <= r_addr;
               r_wrData <= r_data;
               r_pixAck <= 1'b1;
               r_state  <= S_RELEASE;
            end
            S_RELEASE: begin
               if (!pix_done) begin
                  r_pixAck <= 1'b0;
                  r_cnt    <= w_cntNext;
                  r_addr   <= r_addr + ADDR_W'(1);
                  r_state  <= (w_cntNext == r_numPix) ? S_DONE : S_WAIT;
               end
            end
            S_DONE: begin
               r_frameDone <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign pix_ack    = r_pixAck;
   assign wr_en      = r_wrEn;
   assign wr_addr    = r_wrAddr;
   assign wr_data    = r_wrData;
   assign busy       = r_busy;
   assign frame_done = r_frameDone;

endmodule

// File: tb/tb_pixel_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_pixel_writeback_unit
//
// Purpose:
//   Directed self-checking bench for pixel_writeback_unit. It plays the
//   processor side of the done/ack handshake and the controller side of
//   start/frame_done. A negedge monitor logs every RAM write. Each scenario
//   task compares the observed values against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pixel_writeback_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [13:0] out_base_addr;
   logic [13:0] num_pix;
   logic        relu_en;
   logic [31:0] pix_in;
   logic        pix_done;
   logic        pix_ack;
   logic        wr_en;
   logic [13:0] wr_addr;
   logic [15:0] wr_data;
   logic        busy;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   logic [29:0] wrLog[$];
   int          doneCount = 0;

   pixel_writeback_unit #(
      .IN_W(32), .OUT_W(16), .ADDR_W(14), .FRAC_SHIFT(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .out_base_addr(out_base_addr),
      .num_pix(num_pix), .relu_en(relu_en), .pix_in(pix_in),
      .pix_done(pix_done), .pix_ack(pix_ack), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .frame_done(frame_done)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Log every write and count frame_done pulses, sampling mid-cycle.
   always @(negedge clk) begin
      if (wr_en === 1'b1) wrLog.push_back({wr_addr, wr_data});
      if (frame_done === 1'b1) doneCount++;
   end

   // Pulse start for one cycle with the given configuration.
   task automatic startFrame(input logic [13:0] base, input logic [13:0] num,
                             input logic relu);
      @(negedge clk);
      out_base_addr = base;
      num_pix       = num;
      relu_en       = relu;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Processor model: present a pixel, wait for ack, keep done high for
   // holdCycles more cycles, then drop it and wait for ack to fall.
   task automatic sendPixel(input logic [31:0] val, input int holdCycles);
      int n;
      @(negedge clk);
      pix_in   = val;
      pix_done = 1'b1;
      n = 0;
      while (pix_ack !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (pix_ack !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ack_timeout: pix_ack=%b required 1", pix_ack);
      end
      repeat (holdCycles) @(negedge clk);
      pix_done = 1'b0;
      n = 0;
      while (pix_ack !== 1'b0 && n < 5) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Wait (bounded) for frame_done; busy must drop in that same cycle.
   task automatic waitFrameDone();
      int n;
      n = 0;
      while (frame_done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL frame_done_timeout: frame_done=%b required 1", frame_done);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL busy_at_done: busy=%b required 0", busy);
      end
   endtask

   // Compare one logged write against its expected address and data.
   task automatic checkWrite(input string name, input int idx,
                             input logic [13:0] expAddr, input logic [15:0] expData);
      logic [29:0] got;
      got = (idx < wrLog.size()) ? wrLog[idx] : 30'h3FFF_FFFF;
      checks++;
      if (got !== {expAddr, expData}) begin
         errors++;
         $display("[TB] FAIL %s: addr=%0d data=0x%04h required addr=%0d data=0x%04h",
                  name, got[29:16], got[15:0], expAddr, expData);
      end
   endtask

   // Outputs must all be zero straight after reset.
   task automatic test_reset();
      #1;
      checks++;
      if ({pix_ack, wr_en, wr_addr, wr_data, busy, frame_done} !== 34'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: ack=%b wen=%b addr=%0d data=%h busy=%b fd=%b required all 0",
                  pix_ack, wr_en, wr_addr, wr_data, busy, frame_done);
      end
   endtask

   // Three-pixel frame covering in-range, positive and negative saturation.
   task automatic test_basic_frame();
      int base, d0;
      base = wrLog.size();
      d0   = doneCount;
      startFrame(14'd100, 14'd3, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy_after_start: busy=%b required 1", busy);
      end
      sendPixel(32'h0000_1234, 0);
      sendPixel(32'h7FFF_FFFF, 0);
      sendPixel(32'h8000_0000, 0);
      waitFrameDone();
      repeat (3) @(negedge clk);
      checks++;
      if (wrLog.size() - base != 3) begin
         errors++;
         $display("[TB] FAIL basic_write_count: writes=%0d required 3", wrLog.size() - base);
      end
      checkWrite("basic_w0", base,     14'd100, 16'h0012);
      checkWrite("basic_w1", base + 1, 14'd101, 16'h7FFF);
      checkWrite("basic_w2", base + 2, 14'd102, 16'h8000);
      checks++;
      if (doneCount - d0 != 1) begin
         errors++;
         $display("[TB] FAIL basic_done_pulses: pulses=%0d required 1", doneCount - d0);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_busy_after: busy=%b required 0", busy);
      end
   endtask

   // Negative pixel with and without ReLU.
   task automatic test_relu();
      int base;
      base = wrLog.size();
      startFrame(14'd10, 14'd1, 1'b1);
      sendPixel(32'hFFFF_F000, 0);
      waitFrameDone();
      startFrame(14'd11, 14'd1, 1'b0);
      sendPixel(32'hFFFF_F000, 0);
      waitFrameDone();
      checkWrite("relu_on",  base,     14'd10, 16'h0000);
      checkWrite("relu_off", base + 1, 14'd11, 16'hFFF0);
   endtask

   // wr_en and pix_ack appear two edges after the edge that samples done.
   task automatic test_latency();
      int base;
      base = wrLog.size();
      startFrame(14'd7, 14'd1, 1'b1);
      @(negedge clk);
      pix_in   = 32'h0001_2345;
      pix_done = 1'b1;
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL latency_edge1: wr_en=%b required 0", wr_en);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL latency_edge2: wr_en=%b required 0", wr_en);
      end
      @(negedge clk);
      checks++;
      if ({wr_en, pix_ack, wr_addr, wr_data} !== {1'b1, 1'b1, 14'd7, 16'h0123}) begin
         errors++;
         $display("[TB] FAIL latency_write: wen=%b ack=%b addr=%0d data=%h required 1 1 7 0123",
                  wr_en, pix_ack, wr_addr, wr_data);
      end
      pix_done = 1'b0;
      @(negedge clk);
      checks++;
      if ({wr_en, pix_ack, wr_addr, wr_data} !== {1'b0, 1'b0, 14'd7, 16'h0123}) begin
         errors++;
         $display("[TB] FAIL latency_hold: wen=%b ack=%b addr=%0d data=%h required 0 0 7 0123",
                  wr_en, pix_ack, wr_addr, wr_data);
      end
      waitFrameDone();
   endtask

   // Processor keeps done high for 5 cycles after ack.
   task automatic test_hold_done();
      int base, n;
      base = wrLog.size();
      startFrame(14'd300, 14'd1, 1'b0);
      @(negedge clk);
      pix_in   = 32'h0000_4200;
      pix_done = 1'b1;
      n = 0;
      while (pix_ack !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (pix_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_ack_high[%0d]: pix_ack=%b required 1", i, pix_ack);
         end
      end
      pix_done = 1'b0;
      @(negedge clk);
      checks++;
      if (pix_ack !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hold_ack_fall: pix_ack=%b required 0", pix_ack);
      end
      waitFrameDone();
      checks++;
      if (wrLog.size() - base != 1) begin
         errors++;
         $display("[TB] FAIL hold_write_count: writes=%0d required 1", wrLog.size() - base);
      end
      checkWrite("hold_w0", base, 14'd300, 16'h0042);
   endtask

   // Empty frame: frame_done on the second cycle after start, no writes.
   task automatic test_zero_frame();
      int base;
      base = wrLog.size();
      @(negedge clk);
      out_base_addr = 14'd55;
      num_pix       = 14'd0;
      relu_en       = 1'b0;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (frame_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_done_early: frame_done=%b required 0", frame_done);
      end
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL zero_done: frame_done=%b required 1", frame_done);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (wrLog.size() != base) begin
         errors++;
         $display("[TB] FAIL zero_no_write: writes=%0d required 0", wrLog.size() - base);
      end
   endtask

   // Address wrap at the top of the RAM, plus a start pulse while busy.
   task automatic test_wrap();
      int base;
      base = wrLog.size();
      startFrame(14'd16383, 14'd2, 1'b0);
      @(negedge clk);
      out_base_addr = 14'd5;
      num_pix       = 14'd9;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sendPixel(32'h0000_0100, 0);
      sendPixel(32'hFFFF_FF00, 0);
      waitFrameDone();
      checkWrite("wrap_w0", base,     14'd16383, 16'h0001);
      checkWrite("wrap_w1", base + 1, 14'd0,     16'hFFFF);
   endtask

   // done high while idle must be ignored.
   task automatic test_idle_done();
      int base;
      base = wrLog.size();
      @(negedge clk);
      pix_in   = 32'h0000_7700;
      pix_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (pix_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_no_ack[%0d]: pix_ack=%b required 0", i, pix_ack);
         end
      end
      pix_done = 1'b0;
      checks++;
      if (wrLog.size() != base) begin
         errors++;
         $display("[TB] FAIL idle_no_write: writes=%0d required 0", wrLog.size() - base);
      end
   endtask

   // Reset while in RELEASE, then restart cleanly at a new base.
   task automatic test_reset_midframe();
      int base, n;
      startFrame(14'd50, 14'd3, 1'b0);
      @(negedge clk);
      pix_in   = 32'h0000_0500;
      pix_done = 1'b1;
      n = 0;
      while (pix_ack !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({pix_ack, wr_en, wr_addr, wr_data, busy, frame_done} !== 34'd0) begin
         errors++;
         $display("[TB] FAIL midframe_reset: ack=%b wen=%b addr=%0d data=%h busy=%b fd=%b required all 0",
                  pix_ack, wr_en, wr_addr, wr_data, busy, frame_done);
      end
      pix_done = 1'b0;
      @(negedge clk);
      rst  = 1'b0;
      base = wrLog.size();
      startFrame(14'd200, 14'd1, 1'b0);
      sendPixel(32'h0000_2200, 0);
      waitFrameDone();
      checks++;
      if (wrLog.size() - base != 1) begin
         errors++;
         $display("[TB] FAIL restart_write_count: writes=%0d required 1", wrLog.size() - base);
      end
      checkWrite("restart_w0", base, 14'd200, 16'h0022);
   endtask

   initial begin
      rst           = 1'b1;
      start         = 1'b0;
      out_base_addr = '0;
      num_pix       = '0;
      relu_en       = 1'b0;
      pix_in        = '0;
      pix_done      = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_basic_frame();
      test_relu();
      test_latency();
      test_hold_done();
      test_zero_frame();
      test_wrap();
      test_idle_done();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
